// File: rtl/dsram_responder_pkg.sv
// Shared types and constants for the data-SRAM responder: size codes,
// queued request entry and the random-delay LFSR polynomial.
package dsram_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 30;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LFSR_W = 16;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over the state.
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic              wr;
        logic [IDX_W-1:0]  idx;
        logic [3:0]        wstrb;
        logic [DATA_W-1:0] wdata;
    } req_entry_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dsram_req_fifo.sv
// Circular request queue for dsram_responder; exposes its pointers so the
// owner can keep per-slot side state (countdowns) aligned with the entries.
module dsram_req_fifo
    import dsram_responder_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  req_entry_t       entry_i,
    output req_entry_t       head_o,
    output logic [PTR_W-1:0] wptr_o,
    output logic [PTR_W-1:0] rptr_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    req_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign head_o  = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = ptr_inc(wptr_q);
        if (do_pop)  rptr_d = ptr_inc(rptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload storage needs no reset: pointers define which slots are live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= entry_i;
    end

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM slave model: in-order request queue with a minimum response latency.
// Define DSRAM_RAND_DELAY_EN to add 0..3 LFSR-chosen extra cycles per request.
module dsram_responder
    import dsram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned QDEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned WORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] store_q [WORDS];
    logic [CNT_W-1:0]  cnt_q [QDEPTH];
    logic [CNT_W-1:0]  cnt_d [QDEPTH];
    logic [CNT_W-1:0]  load_c;
    req_entry_t        req_c, head_c;
    logic [PTR_W-1:0]  wptr_c, rptr_c;
    logic              full_c, empty_c;
    logic              accept_c, retire_c;
    logic [ADDR_W-1:0] head_idx_c;
    logic              unused_c;

    assign accept_c   = data_sram_req && !full_c;
    assign req_c      = '{wr:    data_sram_wr,
                          idx:   IDX_W'(data_sram_addr[ADDR_W+1:2]),
                          wstrb: data_sram_wstrb,
                          wdata: data_sram_wdata};
    assign head_idx_c = head_c.idx[ADDR_W-1:0];
    assign retire_c   = !empty_c && (cnt_q[rptr_c] == '0);

    dsram_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (accept_c),
        .pop_i   (retire_c),
        .entry_i (req_c),
        .head_o  (head_c),
        .wptr_o  (wptr_c),
        .rptr_o  (rptr_c),
        .full_o  (full_c),
        .empty_o (empty_c)
    );

`ifdef DSRAM_RAND_DELAY_EN
    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_next(lfsr_q);
    end

    assign load_c = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
    assign load_c = CNT_W'(LATENCY - 1);
`endif

    // Every slot counts down; stale slots just sit at zero until reloaded.
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : '0;
        end
        if (accept_c) cnt_d[wptr_c] = load_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Store is never cleared; a write retiring under reset is dropped.
    always_ff @(posedge clk) begin
        if (retire_c && head_c.wr && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (head_c.wstrb[b]) store_q[head_idx_c][8*b +: 8] <= head_c.wdata[8*b +: 8];
            end
        end
    end

    assign data_sram_addr_ok = !full_c;
    assign data_sram_data_ok = retire_c;
    assign data_sram_rdata   = (retire_c && !head_c.wr) ? store_q[head_idx_c] : '0;

    // Size is informational and high address bits alias.
    assign unused_c = ^{data_sram_size, data_sram_addr, head_c.idx,
                        (data_sram_size == SIZE_B), (data_sram_size == SIZE_H),
                        (data_sram_size == SIZE_W)};

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: two instances (LATENCY 1 and 3) share stimulus;
// a per-instance queue/array reference model checks every cycle.
module tb_dsram_responder;

    localparam int QD = 2;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [1:0]  addr_ok_w;
    logic [1:0]  data_ok_w;
    logic [31:0] rdata_w [2];

    dsram_responder #(.ADDR_W(10), .LATENCY(1), .QDEPTH(QD)) u_dut_l1 (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
        .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok_w[0]),
        .data_sram_data_ok(data_ok_w[0]), .data_sram_rdata(rdata_w[0]));

    dsram_responder #(.ADDR_W(10), .LATENCY(3), .QDEPTH(QD)) u_dut_l3 (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
        .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok_w[1]),
        .data_sram_data_ok(data_ok_w[1]), .data_sram_rdata(rdata_w[1]));

    typedef struct {
        logic        wr;
        int unsigned idx;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        longint      acc;
    } pend_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    pend_t       pend [2][16];
    int          ph [2];
    int          pt [2];
    longint      prev_ret [2];
    logic [31:0] mem_m [2][1024];
    logic [3:0]  kn_m  [2][1024];
    int          resp_cnt [2];
    logic [31:0] last_rdata [2];
    longint      cyc;
    int          checks;
    int          errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint lat(input int k);
        return (k == 0) ? 64'sd1 : 64'sd3;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h expected %h (cycle %0d)", nm, k, act, exp, cyc);
        end
    endtask

    // Reference model: pending list in acceptance order, head retires once
    // LATENCY cycles have passed since its acceptance.
    task automatic model_step(input int k);
        pend_t       hd;
        int          n;
        logic        exp_aok, ready, ret, dok;
        logic [31:0] rd, m;
        logic [3:0]  kn;
`ifdef DSRAM_RAND_DELAY_EN
        longint      bound;
`endif
        dok = data_ok_w[k];
        rd  = rdata_w[k];
        if (reset) begin
            ph[k] = 0;
            pt[k] = 0;
            prev_ret[k] = -100;
            return;
        end
        n = pt[k] - ph[k];
        exp_aok = (n < QD);
        chk("addr_ok", k, 32'(addr_ok_w[k]), 32'(exp_aok));
        hd = pend[k][ph[k] % 16];
        ready = (n > 0) && (cyc >= hd.acc + lat(k));
`ifdef DSRAM_RAND_DELAY_EN
        bound = hd.acc + lat(k) + 3;
        if (prev_ret[k] + 1 > bound) bound = prev_ret[k] + 1;
        if (dok) chk("data_ok_ready", k, 32'(ready), 32'd1);
        if (n > 0 && cyc >= bound) chk("data_ok_by_bound", k, 32'(dok), 32'd1);
        ret = dok && ready;
`else
        chk("data_ok", k, 32'(dok), 32'(ready));
        ret = ready;
`endif
        if (ret) begin
            if (!hd.wr) begin
                kn = kn_m[k][hd.idx];
                m = {{8{kn[3]}}, {8{kn[2]}}, {8{kn[1]}}, {8{kn[0]}}};
                if (m != 32'd0) chk("rdata", k, rd & m, mem_m[k][hd.idx] & m);
                last_rdata[k] = rd;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (hd.wstrb[b]) mem_m[k][hd.idx][8*b +: 8] = hd.wdata[8*b +: 8];
                end
                kn_m[k][hd.idx] = kn_m[k][hd.idx] | hd.wstrb;
            end
            resp_cnt[k]++;
            ph[k]++;
            prev_ret[k] = cyc;
        end else begin
            chk("rdata_idle", k, rd, 32'd0);
        end
        if (req && exp_aok) begin
            pend[k][pt[k] % 16] = '{wr: wr, idx: (addr >> 2) % 1024, wstrb: wstrb,
                                    wdata: wdata, acc: cyc};
            pt[k]++;
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
        tick();
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [13];
        int          rc0, rc1;
        logic [31:0] r;
        int unsigned idx;

        tbl[0]  = '{1'b1, 32'h100,  4'hF, 32'h1234_5678, 32'h0};
        tbl[1]  = '{1'b0, 32'h100,  4'h0, 32'h0,         32'h1234_5678};
        tbl[2]  = '{1'b1, 32'h104,  4'hF, 32'hFFFF_FFFF, 32'h0};
        tbl[3]  = '{1'b1, 32'h104,  4'h2, 32'h0000_AB00, 32'h0};
        tbl[4]  = '{1'b0, 32'h104,  4'h0, 32'h0,         32'hFFFF_ABFF};
        tbl[5]  = '{1'b0, 32'h1104, 4'h0, 32'h0,         32'hFFFF_ABFF};
        tbl[6]  = '{1'b0, 32'h107,  4'h0, 32'h0,         32'hFFFF_ABFF};
        tbl[7]  = '{1'b1, 32'h108,  4'hF, 32'hCAFE_F00D, 32'h0};
        tbl[8]  = '{1'b1, 32'h108,  4'h0, 32'hDEAD_BEEF, 32'h0};
        tbl[9]  = '{1'b0, 32'h108,  4'h0, 32'h0,         32'hCAFE_F00D};
        tbl[10] = '{1'b1, 32'h10C,  4'hF, 32'h0,         32'h0};
        tbl[11] = '{1'b1, 32'h10C,  4'h9, 32'hAABB_CCDD, 32'h0};
        tbl[12] = '{1'b0, 32'h10C,  4'h0, 32'h0,         32'hAA00_00DD};

        checks = 0; errors = 0; cyc = 0;
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; pt[k] = 0; prev_ret[k] = -100; resp_cnt[k] = 0; last_rdata[k] = '0;
            for (int i = 0; i < 1024; i++) begin
                mem_m[k][i] = '0;
                kn_m[k][i] = '0;
            end
        end
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wstrb = '0; wdata = '0;
        idle(3);
        reset = 1'b0;
        chk("reset_addr_ok", 0, 32'(addr_ok_w), 32'h3);
        chk("reset_data_ok", 0, 32'(data_ok_w), 32'h0);
        chk("reset_rdata", 1, rdata_w[1], 32'h0);

        // Isolated requests with hand-computed results.
        for (int i = 0; i < 13; i++) begin
            rc0 = resp_cnt[0]; rc1 = resp_cnt[1];
            issue(tbl[i].wr, tbl[i].addr, tbl[i].wstrb, tbl[i].wdata);
            idle(5);
            chk("tbl_resp", 0, 32'(resp_cnt[0] - rc0), 32'd1);
            chk("tbl_resp", 1, 32'(resp_cnt[1] - rc1), 32'd1);
            if (!tbl[i].wr) begin
                chk("tbl_rdata", 0, last_rdata[0], tbl[i].exp);
                chk("tbl_rdata", 1, last_rdata[1], tbl[i].exp);
            end
        end

        // Request held high: LATENCY 3 instance fills after two accepts.
        req = 1'b1; wr = 1'b0; wstrb = '0; wdata = '0;
        for (int i = 0; i < 10; i++) begin
            addr = 32'h100 + 32'(4 * (i % 4));
            tick();
            if (i == 1) begin
                chk("full_addr_ok", 1, 32'(addr_ok_w[1]), 32'd0);
                chk("flow_addr_ok", 0, 32'(addr_ok_w[0]), 32'd1);
            end
        end
        req = 1'b0;
        idle(8);

        // Back-to-back write then read of the same word.
        issue(1'b1, 32'h200, 4'hF, 32'h0BAD_CAFE);
        issue(1'b0, 32'h200, 4'h0, 32'h0);
        idle(6);
        chk("wr_rd_b2b", 0, last_rdata[0], 32'h0BAD_CAFE);
        chk("wr_rd_b2b", 1, last_rdata[1], 32'h0BAD_CAFE);

        // Reset with requests outstanding, including a pending write.
        issue(1'b0, 32'h100, 4'h0, 32'h0);
        issue(1'b0, 32'h104, 4'h0, 32'h0);
        issue(1'b1, 32'h104, 4'hF, 32'h5555_5555);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rc0 = resp_cnt[0]; rc1 = resp_cnt[1];
        chk("post_rst_addr_ok", 0, 32'(addr_ok_w), 32'h3);
        chk("post_rst_data_ok", 0, 32'(data_ok_w), 32'h0);
        idle(6);
        chk("dropped_resp", 0, 32'(resp_cnt[0] - rc0), 32'd0);
        chk("dropped_resp", 1, 32'(resp_cnt[1] - rc1), 32'd0);
        issue(1'b0, 32'h104, 4'h0, 32'h0);
        idle(5);
        chk("store_kept", 0, last_rdata[0], 32'hFFFF_ABFF);
        chk("store_kept", 1, last_rdata[1], 32'hFFFF_ABFF);

        // Random traffic over 32 words with aliasing high/low address bits.
        for (int i = 0; i < 800; i++) begin
            r     = $urandom;
            idx   = $urandom_range(0, 31);
            req   = ($urandom_range(0, 3) != 0);
            wr    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 2));
            addr  = {r[31:12], 5'd0, 5'(idx), r[1:0]};
            wstrb = 4'($urandom);
            wdata = $urandom;
            tick();
        end
        req = 1'b0;
        idle(20);

        // Read back every exercised word; the model checks each response.
        for (int i = 0; i < 32; i++) begin
            issue(1'b0, 32'(i * 4), 4'h0, 32'h0);
            idle(4);
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
